// File: rtl/traffic_density_sensor_pkg.sv
// Shared density-level definitions, used by this sensor and by the traffic light controller.
package traffic_density_sensor_pkg;

  typedef logic [1:0] level_t;

  localparam level_t LVL_LOW  = 2'b00;
  localparam level_t LVL_MED  = 2'b01;
  localparam level_t LVL_HIGH = 2'b10;

  function automatic level_t classify(input int unsigned total,
                                      input int unsigned med_th,
                                      input int unsigned high_th);
    if (total >= high_th) return LVL_HIGH;
    if (total >= med_th) return LVL_MED;
    return LVL_LOW;
  endfunction

endpackage

// File: rtl/density_channel.sv
// One detector road: synchronizer, debounce filter, rising-edge event and saturating arrival count.
module density_channel #(
  parameter int unsigned CNT_W = 6,
  parameter int unsigned DEB   = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             raw_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             event_o
);

  localparam int unsigned RunW = (DEB > 1) ? $clog2(DEB) : 1;

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d;
  logic [RunW-1:0]  run_q, run_d;
  logic             ev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    // run_q counts consecutive disagreeing samples; the DEB-th one flips the level.
    if (sync2_q != filt_q) begin
      if (run_q == RunW'(DEB - 1)) filt_d = sync2_q;
      else                         run_d  = run_q + 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                       cnt_d = '0;
    else if (ev_q && (cnt_q != '1))  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      run_q   <= '0;
      ev_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      run_q   <= run_d;
      ev_q    <= filt_d & ~filt_q;
      cnt_q   <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign event_o = ev_q;

endmodule

// File: rtl/traffic_density_sensor.sv
// Per-road vehicle density classifier: counts debounced arrivals over a fixed window and
// reports LOW/MED/HIGH once per window.
module traffic_density_sensor
  import traffic_density_sensor_pkg::*;
#(
  parameter int unsigned WINDOW  = 10,
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned MED_TH  = 3,
  parameter int unsigned HIGH_TH = 6,
  parameter int unsigned DEB     = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   veh_A,
  input  logic   veh_B,
  input  logic   veh_C,
  output level_t traffic_A,
  output level_t traffic_B,
  output level_t traffic_C,
  output logic   sample_valid
);

  localparam int unsigned WinW = $clog2(WINDOW);

  logic [WinW-1:0]  win_q, win_d;
  logic             window_end;
  logic [2:0]       raw, ev;
  logic [CNT_W-1:0] cnt   [3];
  logic [CNT_W-1:0] total [3];
  level_t           lvl_q [3];
  level_t           lvl_d [3];
  logic             valid_q;

  assign raw        = {veh_C, veh_B, veh_A};
  assign window_end = (win_q == WinW'(WINDOW - 1));
  assign win_d      = window_end ? '0 : win_q + 1'b1;

  for (genvar r = 0; r < 3; r++) begin : g_chan
    density_channel #(
      .CNT_W (CNT_W),
      .DEB   (DEB)
    ) u_chan (
      .clk_i   (clk),
      .rst_ni  (reset),
      .raw_i   (raw[r]),
      .clr_i   (window_end),
      .count_o (cnt[r]),
      .event_o (ev[r])
    );
  end

  // An event present in the closing cycle still belongs to the closing window.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      total[r] = (ev[r] && (cnt[r] != '1)) ? cnt[r] + 1'b1 : cnt[r];
      lvl_d[r] = window_end ? classify(32'(total[r]), MED_TH, HIGH_TH) : lvl_q[r];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q   <= '0;
      valid_q <= 1'b0;
      for (int r = 0; r < 3; r++) lvl_q[r] <= LVL_LOW;
    end else begin
      win_q   <= win_d;
      valid_q <= window_end;
      for (int r = 0; r < 3; r++) lvl_q[r] <= lvl_d[r];
    end
  end

  assign traffic_A    = lvl_q[0];
  assign traffic_B    = lvl_q[1];
  assign traffic_C    = lvl_q[2];
  assign sample_valid = valid_q;

endmodule
